// File: rtl/usr_axil_csr_if.sv
// AXI-Lite bus bundle between a host-side master and the usr_axil_csr register block.
interface usr_axil_csr_if #(
  parameter int AXIL_AW = 32,
  parameter int AXIL_DW = 32
);
  logic [AXIL_AW-1:0]   s_axil_awaddr;
  logic                 s_axil_awvalid;
  logic                 s_axil_awready;
  logic [AXIL_DW-1:0]   s_axil_wdata;
  logic [AXIL_DW/8-1:0] s_axil_wstrb;
  logic                 s_axil_wvalid;
  logic                 s_axil_wready;
  logic [1:0]           s_axil_bresp;
  logic                 s_axil_bvalid;
  logic                 s_axil_bready;
  logic [AXIL_AW-1:0]   s_axil_araddr;
  logic                 s_axil_arvalid;
  logic                 s_axil_arready;
  logic [AXIL_DW-1:0]   s_axil_rdata;
  logic [1:0]           s_axil_rresp;
  logic                 s_axil_rvalid;
  logic                 s_axil_rready;

  modport slave (
    input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
           s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready,
    output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
           s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );

  modport master (
    output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
           s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready,
    input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
           s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );
endinterface

// File: rtl/usr_axil_csr.sv
// AXI-Lite CSR block in front of the matmul core: start pulse, run/done tracking, cycle counter.
// Optional IRQ_EN register and level interrupt are enabled by defining USR_CSR_IRQ_EN.
module usr_axil_csr #(
  parameter int          AXIL_AW      = 32,
  parameter int          AXIL_DW      = 32,
  parameter logic [31:0] ADDR_CTRL    = 32'h0000_0000,
  parameter logic [31:0] ADDR_STATUS  = 32'h0000_1000,
  parameter logic [31:0] ADDR_CYCLES  = 32'h0000_1004,
  parameter logic [31:0] ADDR_SCRATCH = 32'h0000_1008
) (
  input  logic          user_clk,
  input  logic          user_resetn,
  usr_axil_csr_if.slave s_axil,
  output logic          core_start,
  input  logic          core_finish,
  output logic          irq
);
  localparam int          STRB_W      = AXIL_DW / 8;
  localparam logic [31:0] ADDR_IRQ_EN = 32'h0000_100C;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef logic [13:0] widx_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

  function automatic logic is_mapped(input widx_t idx);
    logic hit;
    hit = (idx == ADDR_CTRL[15:2])   || (idx == ADDR_STATUS[15:2]) ||
          (idx == ADDR_CYCLES[15:2]) || (idx == ADDR_SCRATCH[15:2]);
`ifdef USR_CSR_IRQ_EN
    hit = hit || (idx == ADDR_IRQ_EN[15:2]);
`endif
    return hit;
  endfunction

  // Bus-side state
  logic                bus_en_q;
  logic                aw_vld_q;
  widx_t               aw_idx_q;
  logic                w_vld_q;
  logic [AXIL_DW-1:0]  wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic                rvalid_q;
  logic [AXIL_DW-1:0]  rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  widx_t               rd_idx;

  // Core-side state
  state_t              state_q, state_d;
  logic                core_start_q;
  logic                start_err_q;
  logic [31:0]         cycles_q;
  logic [AXIL_DW-1:0]  scratch_q;
`ifdef USR_CSR_IRQ_EN
  logic                irq_en_q;
  logic                irq_q;
`endif

  logic awready, wready, arready;
  logic aw_hs, w_hs, ar_hs, b_hs, commit;
  logic wr_ctrl, wr_status, wr_scratch;
  logic start_req, clr_done, clr_err;
  logic busy, done, start_ok, start_err_set;
  logic unused_addr_bits;

  // bus_en_q keeps every ready low while reset is held and for the first edge after it.
  assign awready = bus_en_q & ~aw_vld_q & ~bvalid_q;
  assign wready  = bus_en_q & ~w_vld_q  & ~bvalid_q;
  assign arready = bus_en_q & ~rvalid_q;

  assign aw_hs  = s_axil.s_axil_awvalid & awready;
  assign w_hs   = s_axil.s_axil_wvalid  & wready;
  assign ar_hs  = s_axil.s_axil_arvalid & arready;
  assign b_hs   = bvalid_q & s_axil.s_axil_bready;
  assign commit = aw_vld_q & w_vld_q & ~bvalid_q;

  assign wr_ctrl    = commit && (aw_idx_q == ADDR_CTRL[15:2]);
  assign wr_status  = commit && (aw_idx_q == ADDR_STATUS[15:2]);
  assign wr_scratch = commit && (aw_idx_q == ADDR_SCRATCH[15:2]);
  assign start_req  = wr_ctrl   && wstrb_q[0] && wdata_q[0];
  assign clr_done   = wr_status && wstrb_q[0] && wdata_q[1];
  assign clr_err    = wr_status && wstrb_q[0] && wdata_q[2];

  assign s_axil.s_axil_awready = awready;
  assign s_axil.s_axil_wready  = wready;
  assign s_axil.s_axil_bvalid  = bvalid_q;
  assign s_axil.s_axil_bresp   = bresp_q;
  assign s_axil.s_axil_arready = arready;
  assign s_axil.s_axil_rvalid  = rvalid_q;
  assign s_axil.s_axil_rdata   = rdata_q;
  assign s_axil.s_axil_rresp   = rresp_q;
  assign core_start            = core_start_q;

  assign unused_addr_bits = ^{s_axil.s_axil_awaddr[AXIL_AW-1:16], s_axil.s_axil_awaddr[1:0],
                              s_axil.s_axil_araddr[AXIL_AW-1:16], s_axil.s_axil_araddr[1:0]};

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      bus_en_q <= 1'b0;
      aw_vld_q <= 1'b0;
      aw_idx_q <= '0;
      w_vld_q  <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      bus_en_q <= 1'b1;
      if (b_hs) begin
        aw_vld_q <= 1'b0;
        w_vld_q  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_vld_q <= 1'b1;
          aw_idx_q <= s_axil.s_axil_awaddr[15:2];
        end
        if (w_hs) begin
          w_vld_q <= 1'b1;
          wdata_q <= s_axil.s_axil_wdata;
          wstrb_q <= s_axil.s_axil_wstrb;
        end
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= is_mapped(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read data is captured at the AR handshake, so CYCLES reflects that instant.
  always_comb begin
    rd_idx  = s_axil.s_axil_araddr[15:2];
    rdata_d = '0;
    rresp_d = is_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
    case (rd_idx)
      ADDR_STATUS[15:2]:  rdata_d[2:0] = {start_err_q, done, busy};
      ADDR_CYCLES[15:2]:  rdata_d      = cycles_q;
      ADDR_SCRATCH[15:2]: rdata_d      = scratch_q;
`ifdef USR_CSR_IRQ_EN
      ADDR_IRQ_EN[15:2]:  rdata_d[0]   = irq_en_q;
`endif
      default:            rdata_d      = '0;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end else if (s_axil.s_axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_req) state_d = ST_RUN;
      ST_RUN:  if (core_finish) state_d = ST_DONE;
      ST_DONE: begin
        if (start_req)     state_d = ST_RUN;
        else if (clr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A START that lands while running is refused, even when finish arrives the same cycle.
  always_comb begin
    busy          = (state_q == ST_RUN);
    done          = (state_q == ST_DONE);
    start_ok      = start_req && (state_q != ST_RUN);
    start_err_set = start_req && (state_q == ST_RUN);
  end

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      core_start_q <= 1'b0;
      start_err_q  <= 1'b0;
      cycles_q     <= '0;
      scratch_q    <= '0;
    end else begin
      core_start_q <= start_ok;
      if (start_err_set)  start_err_q <= 1'b1;
      else if (clr_err)   start_err_q <= 1'b0;
      if (start_ok)                          cycles_q <= '0;
      else if (busy && (cycles_q != '1))     cycles_q <= cycles_q + 32'd1;
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_scratch && wstrb_q[i]) scratch_q[8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

`ifdef USR_CSR_IRQ_EN
  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (commit && (aw_idx_q == ADDR_IRQ_EN[15:2]) && wstrb_q[0]) irq_en_q <= wdata_q[0];
      irq_q <= done & irq_en_q;
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_usr_axil_csr.sv
// Self-checking bench for usr_axil_csr: vector table, directed run/handshake sequences, random scratch traffic.
`timescale 1ns/1ps
module tb_usr_axil_csr;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef USR_CSR_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic core_start;
  logic core_finish = 1'b0;
  logic irq;

  usr_axil_csr_if #(.AXIL_AW(AW), .AXIL_DW(DW)) bus ();

  usr_axil_csr #(.AXIL_AW(AW), .AXIL_DW(DW)) dut (
    .user_clk    (clk),
    .user_resetn (rst_n),
    .s_axil      (bus),
    .core_start  (core_start),
    .core_finish (core_finish),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (core_start === 1'b1) begin
    start_cnt <= start_cnt + 1;
    start_cyc <= cyc;
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [1:0] resp);
    bit aw_done, w_done, aw_fire, w_fire;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    bus.s_axil_awaddr = a; bus.s_axil_awvalid = 1'b1;
    bus.s_axil_wdata = d;  bus.s_axil_wstrb = s; bus.s_axil_wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 40) begin
      aw_fire = bus.s_axil_awvalid && bus.s_axil_awready;
      w_fire  = bus.s_axil_wvalid && bus.s_axil_wready;
      tick(1); n++;
      if (aw_fire) begin aw_done = 1; bus.s_axil_awvalid = 1'b0; end
      if (w_fire)  begin w_done = 1;  bus.s_axil_wvalid = 1'b0; end
    end
    bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0;
    bus.s_axil_bready = 1'b1;
    while (!bus.s_axil_bvalid && n < 40) begin tick(1); n++; end
    chk("wr_timeout", (n >= 40) ? 32'd1 : 32'd0, 32'd0);
    resp = bus.s_axil_bresp;
    tick(1);
    bus.s_axil_bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    bus.s_axil_araddr = a; bus.s_axil_arvalid = 1'b1;
    while (!bus.s_axil_arready && n < 40) begin tick(1); n++; end
    tick(1);
    bus.s_axil_arvalid = 1'b0;
    while (!bus.s_axil_rvalid && n < 40) begin tick(1); n++; end
    chk("rd_timeout", (n >= 40) ? 32'd1 : 32'd0, 32'd0);
    d = bus.s_axil_rdata; resp = bus.s_axil_rresp;
    bus.s_axil_rready = 1'b1;
    tick(1);
    bus.s_axil_rready = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp_d,
                        input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    axi_rd(a, d, r);
    chk({nm, "_data"}, d, exp_d);
    chk({nm, "_resp"}, 32'(r), 32'(exp_r));
  endtask

  task automatic wr_chk(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] exp_r);
    logic [1:0] r;
    axi_wr(a, d, s, r);
    chk({nm, "_bresp"}, 32'(r), 32'(exp_r));
  endtask

  task automatic pulse_finish();
    core_finish = 1'b1;
    tick(1);
    core_finish = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_valids"}, 32'({bus.s_axil_bvalid, bus.s_axil_rvalid}), 32'd0);
    chk({nm, "_readys"}, 32'({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready}), 32'd0);
    chk({nm, "_resp"}, 32'({bus.s_axil_bresp, bus.s_axil_rresp}), 32'd0);
    chk({nm, "_rdata"}, bus.s_axil_rdata, 32'd0);
    chk({nm, "_start_irq"}, 32'({core_start, irq}), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run still active at 500us, required completion");
    $fatal(1);
  end

  initial begin : main
    vec_t        vt [12];
    logic [1:0]  r;
    logic [31:0] d, m_scratch, addr, data;
    logic [15:0] offs;
    logic [3:0]  strb;
    bit          m_irq_en, mapped;
    int          s0, sel, bv, extra;

    bus.s_axil_awaddr = '0; bus.s_axil_awvalid = 1'b0;
    bus.s_axil_wdata = '0;  bus.s_axil_wstrb = '0; bus.s_axil_wvalid = 1'b0;
    bus.s_axil_bready = 1'b0;
    bus.s_axil_araddr = '0; bus.s_axil_arvalid = 1'b0; bus.s_axil_rready = 1'b0;

    #1 rst_n = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick(1);

    vt[0]  = '{1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 2'b00};
    vt[1]  = '{1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'h0, 2'b10};
    vt[2]  = '{1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'h0, 2'b00};
    vt[3]  = '{1'b0, 32'h0000_1008, 32'h0, 4'h0, 32'h0, 2'b00};
    vt[4]  = '{1'b1, 32'h0000_1008, 32'h1234_5678, 4'hF, 32'h0, 2'b00};
    vt[5]  = '{1'b0, 32'h0001_100B, 32'h0, 4'h0, 32'h1234_5678, 2'b00};
    vt[6]  = '{1'b1, 32'h0000_3008, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10};
    vt[7]  = '{1'b0, 32'hABCD_1008, 32'h0, 4'h0, 32'h1234_5678, 2'b00};
    vt[8]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFE, 4'hF, 32'h0, 2'b00};
    vt[9]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 4'hE, 32'h0, 2'b00};
    vt[10] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0, 2'b00};
    vt[11] = '{1'b0, 32'h0000_100C, 32'h0, 4'h0, 32'h0, IRQ_BUILD ? 2'b00 : 2'b10};
    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) wr_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].strb, vt[i].exp_r);
      else          rd_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].exp_d, vt[i].exp_r);
    end
    rd_chk("status_after_vec", 32'h1000, 32'h0, 2'b00);
    chk("no_start_from_vec", 32'(start_cnt), 32'd0);

    // Start a run, finish it 50 cycles after the start pulse.
    s0 = start_cnt;
    wr_chk("start1", 32'h0, 32'h1, 4'h1, 2'b00);
    tick(3);
    chk("start1_pulse_cycles", 32'(start_cnt - s0), 32'd1);
    rd_chk("status_run", 32'h1000, 32'h1, 2'b00);
    while (cyc < start_cyc + 49) tick(1);
    pulse_finish();
    rd_chk("status_done", 32'h1000, 32'h2, 2'b00);
    rd_chk("cycles_50", 32'h1004, 32'd50, 2'b00);
    pulse_finish();
    tick(5);
    rd_chk("status_done_hold", 32'h1000, 32'h2, 2'b00);
    rd_chk("cycles_hold", 32'h1004, 32'd50, 2'b00);

    // START from DONE, then a refused START while running.
    s0 = start_cnt;
    wr_chk("start2", 32'h0, 32'h1, 4'h1, 2'b00);
    rd_chk("status_run2", 32'h1000, 32'h1, 2'b00);
    wr_chk("start_busy", 32'h0, 32'h1, 4'h1, 2'b00);
    tick(2);
    chk("start_busy_no_pulse", 32'(start_cnt - s0), 32'd1);
    rd_chk("status_err", 32'h1000, 32'h5, 2'b00);
    wr_chk("clr_err", 32'h1000, 32'h4, 4'h1, 2'b00);
    rd_chk("status_err_clr", 32'h1000, 32'h1, 2'b00);

    // START commit and core_finish on the same edge while running.
    s0 = start_cnt;
    chk("collide_ready", 32'({bus.s_axil_awready, bus.s_axil_wready}), 32'd3);
    bus.s_axil_awaddr = 32'h0; bus.s_axil_awvalid = 1'b1;
    bus.s_axil_wdata = 32'h1;  bus.s_axil_wstrb = 4'h1; bus.s_axil_wvalid = 1'b1;
    tick(1);
    bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0;
    core_finish = 1'b1;
    tick(1);
    core_finish = 1'b0;
    chk("collide_bvalid", 32'(bus.s_axil_bvalid), 32'd1);
    bus.s_axil_bready = 1'b1;
    tick(1);
    bus.s_axil_bready = 1'b0;
    tick(2);
    chk("collide_no_pulse", 32'(start_cnt - s0), 32'd0);
    rd_chk("status_collide", 32'h1000, 32'h6, 2'b00);
    wr_chk("clr_nostrb", 32'h1000, 32'h6, 4'h2, 2'b00);
    rd_chk("status_nostrb", 32'h1000, 32'h6, 2'b00);
    wr_chk("clr_all", 32'h1000, 32'h6, 4'h1, 2'b00);
    rd_chk("status_idle", 32'h1000, 32'h0, 2'b00);

    // Interrupt behaviour on a completed run.
    wr_chk("irq_en_set", 32'h100C, 32'h1, 4'h1, IRQ_BUILD ? 2'b00 : 2'b10);
    wr_chk("start3", 32'h0, 32'h1, 4'h1, 2'b00);
    tick(4);
    pulse_finish();
    tick(2);
`ifdef USR_CSR_IRQ_EN
    chk("irq_on_done", 32'(irq), 32'd1);
    rd_chk("irq_en_read", 32'h100C, 32'h1, 2'b00);
    wr_chk("irq_en_off", 32'h100C, 32'h0, 4'h1, 2'b00);
    chk("irq_en_off_irq", 32'(irq), 32'd0);
    wr_chk("irq_en_on", 32'h100C, 32'h1, 4'h1, 2'b00);
    chk("irq_en_on_irq", 32'(irq), 32'd1);
    wr_chk("irq_clr_done", 32'h1000, 32'h2, 4'h1, 2'b00);
    chk("irq_after_clr", 32'(irq), 32'd0);
`else
    chk("irq_tied_low", 32'(irq), 32'd0);
    rd_chk("irq_en_unmapped", 32'h100C, 32'h0, 2'b10);
    wr_chk("irq_clr_done", 32'h1000, 32'h2, 4'h1, 2'b00);
`endif
    rd_chk("status_after_irq", 32'h1000, 32'h0, 2'b00);

    // W leads AW by three cycles; B is held off for four cycles.
    wr_chk("scratch_zero", 32'h1008, 32'h0, 4'hF, 2'b00);
    bus.s_axil_wdata = 32'hAABB_CCDD; bus.s_axil_wstrb = 4'b0101; bus.s_axil_wvalid = 1'b1;
    chk("w_early_ready", 32'(bus.s_axil_wready), 32'd1);
    tick(1);
    bus.s_axil_wvalid = 1'b0;
    tick(2);
    bus.s_axil_awaddr = 32'h1008; bus.s_axil_awvalid = 1'b1;
    chk("aw_late_ready", 32'(bus.s_axil_awready), 32'd1);
    tick(1);
    bus.s_axil_awvalid = 1'b0;
    tick(1);
    bv = 0; extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.s_axil_bvalid) bv++;
      if (bus.s_axil_awready || bus.s_axil_wready) extra++;
      tick(1);
    end
    chk("bvalid_held", 32'(bv), 32'd4);
    chk("no_ready_while_b", 32'(extra), 32'd0);
    chk("bresp_split", 32'(bus.s_axil_bresp), 32'd0);
    bus.s_axil_bready = 1'b1;
    tick(1);
    bus.s_axil_bready = 1'b0;
    chk("bvalid_drop", 32'(bus.s_axil_bvalid), 32'd0);
    rd_chk("scratch_bytes", 32'h1008, 32'h00BB_00DD, 2'b00);

    // Reset asserted mid-run with a read response pending.
    s0 = start_cnt;
    wr_chk("start4", 32'h0, 32'h1, 4'h1, 2'b00);
    tick(5);
    bus.s_axil_araddr = 32'h1004; bus.s_axil_arvalid = 1'b1;
    tick(1);
    bus.s_axil_arvalid = 1'b0;
    chk("rvalid_pending", 32'(bus.s_axil_rvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("midrun_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick(60);
    chk("no_start_after_reset", 32'(start_cnt - s0), 32'd1);
    rd_chk("status_post_reset", 32'h1000, 32'h0, 2'b00);
    rd_chk("cycles_post_reset", 32'h1004, 32'h0, 2'b00);

    // Random traffic against a register-map model (no runs started).
    m_scratch = 32'h0; m_irq_en = 1'b0;
    for (int k = 0; k < 150; k++) begin
      sel  = int'($urandom_range(0, 5));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      case (sel)
        0: offs = 16'h0000;
        1: offs = 16'h1000;
        2: offs = 16'h1004;
        3: offs = 16'h1008;
        4: offs = 16'h100C;
        default: offs = 16'h4000 | 16'($urandom_range(0, 255) << 2);
      endcase
      addr   = {16'($urandom_range(0, 65535)), offs[15:2], 2'($urandom_range(0, 3))};
      mapped = (sel <= 3) || (sel == 4 && IRQ_BUILD);
      if ($urandom_range(0, 1) == 1) begin
        if (sel == 0 && strb[0]) data[0] = 1'b0;
        wr_chk($sformatf("rnd%0d_wr", k), addr, data, strb, mapped ? 2'b00 : 2'b10);
        if (sel == 3) begin
          for (int b = 0; b < 4; b++) if (strb[b]) m_scratch[8*b +: 8] = data[8*b +: 8];
        end
        if (sel == 4 && IRQ_BUILD && strb[0]) m_irq_en = data[0];
      end else begin
        if (sel == 3)                   d = m_scratch;
        else if (sel == 4 && IRQ_BUILD) d = {31'h0, m_irq_en};
        else                            d = 32'h0;
        rd_chk($sformatf("rnd%0d_rd", k), addr, d, mapped ? 2'b00 : 2'b10);
      end
    end
    chk("rnd_no_start", 32'(start_cnt - s0), 32'd1);
    chk("rnd_irq_low", 32'(irq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
